uart_tx_ser: RTL and testbench
==============================

UART_TX_SER -- requirements
Module: uart_tx_ser

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, number of tick16 pulses per serial bit.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tick16  input  1  one-clk baud enable pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port wr_valid  input  1  a write byte is presented.
REQ-007 SHALL have port wr_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port wr_data  input  8  byte to transmit.
REQ-009 SHALL have port parity_en  input  1  append a parity bit.
REQ-010 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-011 SHALL have port two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-012 SHALL have port cts  input  1  clear-to-send, active-high; used only per REQ-032.
REQ-013 SHALL have port stx  output  1  serial transmit line, idle high.
REQ-014 SHALL have port busy  output  1  a frame is in progress.
REQ-015 SHALL have port fifo_count  output  $clog2(DEPTH)+1  number of queued bytes.

Function
REQ-016 SHALL accept a byte on any clk edge where wr_valid && wr_ready; wr_ready = (fifo_count < DEPTH), taken from the registered count.
REQ-017 A write to a full FIFO SHALL be dropped, even if a pop occurs on the same cycle.
REQ-018 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-019 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-020 IDLE->START SHALL occur on a tick16 cycle with fifo_count>0; on that edge the head byte is popped, parity_en/parity_odd/two_stop are latched, and stx goes 0.
REQ-021 Every bit SHALL be held for exactly OVERSAMPLE tick16 pulses, counted by a bit-tick counter; stx SHALL change only on the clk edge of a tick16 cycle.
REQ-022 In DATA, SHALL send 8 bits LSB first.
REQ-023 PARITY SHALL be entered only if latched parity_en=1; the parity bit SHALL be ^data for even parity and ~^data for odd parity.
REQ-024 STOP SHALL drive stx=1 for 1 bit, or 2 bits when latched two_stop=1.
REQ-025 At the end of STOP with fifo_count>0, SHALL go directly to START with no idle gap; otherwise SHALL go to IDLE.
REQ-026 Changes to parity_en, parity_odd or two_stop mid-frame SHALL NOT affect the current frame.
REQ-027 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-028 stx SHALL be registered and glitch-free; in IDLE it SHALL be 1.

Reset
REQ-029 While rst_n=0, SHALL force: state IDLE, stx=1, busy=0, fifo_count=0, wr_ready=1, all counters 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately (stx=1 asynchronously) and discard queued bytes.
REQ-031 After rst_n deasserts, the first write SHALL be accepted on the first clk edge.

Configuration
REQ-032 With UART_TX_CTS_FLOW_EN defined, IDLE->START and STOP->START SHALL additionally require cts=1 on that tick16 cycle; a frame already started SHALL complete regardless of cts.
REQ-033 With UART_TX_CTS_FLOW_EN undefined, cts SHALL be ignored, and the port SHALL remain present in both builds.

Verification
REQ-034 tick16 every 4 clk; write 0x55, parity_en=0, two_stop=0 -> stx: 0 for 16 ticks, then 1,0,1,0,1,0,1,0 at 16 ticks each, then 1 for 16 ticks; busy high for 160 ticks.
REQ-035 Write 0x07 with parity_en=1, parity_odd=0 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame length 176 ticks.
REQ-036 tick16 held 0; write 5 bytes back-to-back -> 4 accepted, fifo_count=4, wr_ready=0 from the cycle after the 4th write, 5th byte dropped.
REQ-037 Queue 0xA1 and 0x3C with two_stop=1 -> stx=1 for exactly 32 ticks after the first frame, then the start bit of 0x3C with no gap.
REQ-038 Pulse rst_n low at data bit 3 of a frame with 2 bytes queued -> stx=1 and fifo_count=0 immediately, busy=0, no further frames.
REQ-039 With UART_TX_CTS_FLOW_EN: cts=0, write 0x80 -> stx stays 1; raise cts -> start bit on the next tick16; dropping cts mid-frame does not truncate the frame.

Source files
------------

// File: rtl/uart_tx_ser.sv
// UART serialiser with a small byte FIFO, optional parity and one/two stop bits.
// Define UART_TX_CTS_FLOW_EN to gate frame starts on cts; otherwise cts is ignored.
module uart_tx_ser #(
   parameter int DEPTH      = 4,
   parameter int OVERSAMPLE = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick16,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [7:0]               wr_data,
   input  logic                     parity_en,
   input  logic                     parity_odd,
   input  logic                     two_stop,
   input  logic                     cts,
   output logic                     stx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(OVERSAMPLE);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Handshake: a byte moves on every rising clk edge where wr_valid && wr_ready;
   // wr_ready depends only on the registered count, so a full FIFO never accepts.
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          cts_ok;
   logic          start_ok;
   logic          bit_end;
   logic          last_stop;
   logic [7:0]    head;

   logic [2:0]    state;
   logic [TW-1:0] tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_q;
   logic          par_q;
   logic          par_en_q;
   logic          two_stop_q;

`ifdef UART_TX_CTS_FLOW_EN
   assign cts_ok = cts;
`else
   logic unused_cts;
   assign unused_cts = cts;
   assign cts_ok     = 1'b1;
`endif

   assign wr_ready  = (fifo_count < CW'(DEPTH));
   assign push      = wr_valid && wr_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (state != ST_IDLE);
   assign bit_end   = tick16 && (tick_cnt == TW'(OVERSAMPLE - 1));
   assign start_ok  = tick16 && (fifo_count != '0) && cts_ok;
   assign last_stop = !(two_stop_q && (bit_cnt == 3'd0));
   // A frame begins either from idle or straight out of the final stop bit.
   assign pop       = start_ok && ((state == ST_IDLE) ||
                                   ((state == ST_STOP) && bit_end && last_stop));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         stx        <= 1'b1;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
      end else if (tick16) begin
         if (pop) begin
            // Frame settings are captured here so later input changes cannot disturb it.
            state      <= ST_START;
            stx        <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= head;
            par_q      <= parity_odd ? ~^head : ^head;
            par_en_q   <= parity_en;
            two_stop_q <= two_stop;
         end else if (state != ST_IDLE) begin
            if (!bit_end) begin
               tick_cnt <= tick_cnt + 1'b1;
            end else begin
               tick_cnt <= '0;
               case (state)
                  ST_START: begin
                     stx     <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_cnt <= '0;
                     state   <= ST_DATA;
                  end
                  ST_DATA: begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                           stx   <= par_q;
                           state <= ST_PARITY;
                        end else begin
                           stx   <= 1'b1;
                           state <= ST_STOP;
                        end
                     end else begin
                        stx     <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
                  ST_PARITY: begin
                     stx     <= 1'b1;
                     bit_cnt <= '0;
                     state   <= ST_STOP;
                  end
                  ST_STOP: begin
                     if (!last_stop) begin
                        bit_cnt <= 3'd1;
                     end else begin
                        stx   <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end
                  default: begin
                     stx   <= 1'b1;
                     state <= ST_IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: random and directed bytes, with a tick-by-tick frame monitor
// that rebuilds each expected frame from the queued byte and the settings at start.
module tb_uart_tx_ser;

   localparam int DEPTH = 4;
   localparam int OS    = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick16 = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       two_stop = 1'b0;
   logic       cts = 1'b1;
   logic       wr_ready;
   logic       stx;
   logic       busy;
   logic [2:0] fifo_count;

   uart_tx_ser #(.DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
      .clk(clk), .rst_n(rst_n), .tick16(tick16), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_data(wr_data), .parity_en(parity_en),
      .parity_odd(parity_odd), .two_stop(two_stop), .cts(cts), .stx(stx),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   bit         tick_en = 1'b0;
   int         tcnt = 0;
   bit         mon_hold = 1'b0;
   bit         in_frame = 1'b0;
   int         k = 0;
   int         flen = 0;
   int         idle_ticks = 0;
   int         last_gap = -1;
   int         frames_started = 0;
   logic [11:0] fbits;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
   endtask

   // tick16 every 4 clk while enabled
   initial forever begin
      @(negedge clk);
      if (tick_en) begin
         tcnt++;
         tick16 = (tcnt % 4 == 0);
      end else begin
         tcnt   = 0;
         tick16 = 1'b0;
      end
   end

   // Reference frame: start 0, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
   task automatic build_frame(input logic [7:0] b, input logic pe, input logic po, input logic ts);
      int ones;
      int n;
      fbits = '1;
      fbits[0] = 1'b0;
      for (int i = 0; i < 8; i++) fbits[i+1] = b[i];
      n = 9;
      ones = $countones(b);
      if (pe) begin
         fbits[n] = po ? (ones % 2 == 0) : (ones % 2 == 1);
         n++;
      end
      fbits[n] = 1'b1;
      n++;
      if (ts) begin
         fbits[n] = 1'b1;
         n++;
      end
      flen = n;
   endtask

   // Monitor: examines stx/busy after every tick16 edge.
   initial begin
      logic       tk, spe, spo, sts;
      logic [7:0] b;
      forever begin
         @(posedge clk);
         tk = tick16; spe = parity_en; spo = parity_odd; sts = two_stop;
         #1;
         if (!rst_n || mon_hold) begin
            in_frame   = 1'b0;
            idle_ticks = 0;
            continue;
         end
         if (!tk) continue;
         if (in_frame && k == flen * OS) in_frame = 1'b0;
         if (in_frame) begin
            check("stx_bit", stx, fbits[k / OS]);
            check("busy_frame", busy, 1);
            k++;
         end else if (stx === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: start bit seen, expected no frame (t=%0t)", $time);
               b = 8'h00;
            end else begin
               b = exp_q.pop_front();
            end
            build_frame(b, spe, spo, sts);
            frames_started++;
            last_gap   = idle_ticks;
            idle_ticks = 0;
            in_frame   = 1'b1;
            check("busy_start", busy, 1);
            k = 1;
         end else begin
            idle_ticks++;
            check("stx_idle", stx, 1);
            check("busy_idle", busy, 0);
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      int t;
      t = 0;
      while (wr_ready !== 1'b1 && t < 20000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20000) fail_now("write_wait");
      wr_valid = 1'b1;
      wr_data  = b;
      @(posedge clk);
      exp_q.push_back(b);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      tick_en = 1'b1;
      while (!(exp_q.size() == 0 && !in_frame && busy === 1'b0) && t < 30000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 30000) fail_now("drain");
   endtask

   task automatic wait_k(input int kk);
      int t;
      t = 0;
      while (!(in_frame && k >= kk) && t < 20000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20000) fail_now("wait_bit");
   endtask

   initial begin
      int         base;
      int         t;
      logic       rdy;
      logic       tk;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stx", stx, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", wr_ready, 1);

      // First write accepted on the first edge after reset release; 0x55 plain frame.
      tick_en = 1'b1;
      @(negedge clk);
      rst_n    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h55;
      @(posedge clk);
      exp_q.push_back(8'h55);
      #1;
      wr_valid = 1'b0;
      check("first_write_count", fifo_count, 1);
      drain();

      // Even and odd parity on 0x07
      parity_en = 1'b1; parity_odd = 1'b0;
      write_byte(8'h07);
      drain();
      parity_odd = 1'b1;
      write_byte(8'h07);
      drain();

      // Settings changed mid-frame must not affect the frame in flight
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      write_byte(8'hC3);
      wait_k(40);
      parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
      drain();
      parity_en = 1'b0; two_stop = 1'b0;

      // Fill with ticks stopped: 4 accepted, 5th dropped
      tick_en = 1'b0;
      wait_cycles(4);
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'hD0 + 8'(i);
         check("fill_ready", wr_ready, (i < DEPTH) ? 1 : 0);
         @(posedge clk);
         if (i < DEPTH) exp_q.push_back(8'hD0 + 8'(i));
         #1;
      end
      wr_valid = 1'b0;
      check("fill_count", fifo_count, 4);
      check("fill_ready_low", wr_ready, 0);

      // Hold a write against the full FIFO while the first pop happens
      tick_en  = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      t = 0;
      forever begin
         rdy = wr_ready;
         @(posedge clk);
         if (rdy === 1'b1) begin
            exp_q.push_back(8'hEE);
            break;
         end
         #1;
         t++;
         if (t >= 3000) begin
            fail_now("refill");
            break;
         end
      end
      #1;
      wr_valid = 1'b0;
      check("refill_count", fifo_count, 4);
      drain();

      // Two stop bits, back-to-back frames with no idle gap
      two_stop = 1'b1;
      base = frames_started;
      write_byte(8'hA1);
      write_byte(8'h3C);
      t = 0;
      while (frames_started < base + 2 && t < 20000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20000) fail_now("b2b_wait");
      check("b2b_gap", last_gap, 0);
      drain();
      two_stop = 1'b0;

      // Reset mid-frame discards the queue
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      wait_k(4 * OS + 8);
      check("pre_rst_count", fifo_count, 2);
      mon_hold = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_stx", stx, 1);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", wr_ready, 1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_hold = 1'b0;
      base = frames_started;
      wait_cycles(2000);
      check("post_rst_frames", frames_started, base);
      check("post_rst_stx", stx, 1);

`ifdef UART_TX_CTS_FLOW_EN
      cts  = 1'b0;
      base = frames_started;
      write_byte(8'h80);
      wait_cycles(800);
      check("cts_block_frames", frames_started, base);
      check("cts_block_count", fifo_count, 1);
      check("cts_block_stx", stx, 1);
      cts = 1'b1;
      t = 0;
      do begin
         @(posedge clk);
         tk = tick16;
         #1;
         t++;
      end while (tk !== 1'b1 && t < 100);
      check("cts_start_stx", stx, 0);
      wait_k(60);
      cts = 1'b0;
      drain();
      cts = 1'b1;
`else
      cts = 1'b0;
      write_byte(8'h80);
      drain();
      cts = 1'b1;
`endif

      // Randomised bytes and settings, including changes while frames are in flight
      for (int i = 0; i < 20; i++) begin
         parity_en  = 1'($urandom_range(0, 1));
         parity_odd = 1'($urandom_range(0, 1));
         two_stop   = 1'($urandom_range(0, 1));
         write_byte(8'($urandom_range(0, 255)));
         wait_cycles($urandom_range(0, 800));
         if ($urandom_range(0, 3) == 0) begin
            parity_en = ~parity_en;
            two_stop  = ~two_stop;
         end
      end
      drain();
      check("end_queue_empty", exp_q.size(), 0);
      check("end_count", fifo_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
